pc_fetch_unit: RTL and testbench

Program counter and instruction-fetch sequencer for the 8-bit core. Owns the PC, fetches one 8-bit instruction per cycle of its FSM over a req/ack handshake, holds it in the instruction register, and presents the 5-bit immediate field to the sign extender. It consumes the 8-bit sign-extended offset returned from the sign extender, together with branch and jump decisions from the execute stage, to compute the next PC.

---
 rtl/aardvark_pkg.sv | 18 +
 rtl/pc_fetch_unit_if.sv | 24 ++
 rtl/pc_next_calc.sv | 26 ++
 rtl/pc_fetch_unit.sv | 113 +++++++++++
 tb/tb_pc_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/aardvark_pkg.sv
// Shared types and constants for the 8-bit core front end.
package aardvark_pkg;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned IMM_W   = 5;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 8'h00;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StHalt
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory req/ack handshake between the fetch unit and memory.
interface pc_fetch_unit_if;
  import aardvark_pkg::*;

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [PC_W-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );

endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC select: jump > branch (pc+1+offset) > sequential, all mod 256.
module pc_next_calc
  import aardvark_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] sext_imm,
  input  logic [PC_W-1:0] jump_target,
  input  logic            jump,
  input  logic            branch_taken,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] w_pc_plus1;

  assign w_pc_plus1 = pc + 8'd1;

  always_comb begin
    next_pc = w_pc_plus1;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = w_pc_plus1 + sext_imm;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC and fetch sequencer: IDLE -> FETCH -> DECODE -> EXECUTE, with a sticky HALT.
// Optional link register enabled by defining PC_LINK_EN.
module pc_fetch_unit
  import aardvark_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  pc_fetch_unit_if.master     imem,
  output logic [PC_W-1:0]     ir,
  output logic                ir_valid,
  output logic [IMM_W-1:0]    imm5,
  input  logic [PC_W-1:0]     sext_imm,
  input  logic                ex_done,
  input  logic                branch_taken,
  input  logic                jump,
  input  logic [PC_W-1:0]     jump_target,
  input  logic                halt,
  input  logic                link,
  output logic [PC_W-1:0]     lr,
  output logic [PC_W-1:0]     pc,
  output logic                halted
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_d;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_ir;
  logic [PC_W-1:0] w_next_pc;
  logic            w_pc_en;
  logic            w_ir_en;

  pc_next_calc u_pc_next_calc (
    .pc           (r_pc),
    .sext_imm     (sext_imm),
    .jump_target  (jump_target),
    .jump         (jump),
    .branch_taken (branch_taken),
    .next_pc      (w_next_pc)
  );

  always_comb begin
    w_state_d = r_state;
    w_pc_en   = 1'b0;
    w_ir_en   = 1'b0;
    unique case (r_state)
      StIdle:   w_state_d = StFetch;
      StFetch: begin
        if (imem.imem_ack) begin
          w_ir_en   = 1'b1;
          w_state_d = StDecode;
        end
      end
      StDecode: w_state_d = StExecute;
      StExecute: begin
        // Control inputs are only meaningful once execute has resolved.
        if (ex_done) begin
          if (halt) begin
            w_state_d = StHalt;
          end else begin
            w_pc_en   = 1'b1;
            w_state_d = StFetch;
          end
        end
      end
      StHalt:   w_state_d = StHalt;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_pc_en) r_pc <= w_next_pc;
      if (w_ir_en) r_ir <= imem.imem_data;
    end
  end

`ifdef PC_LINK_EN
  logic [PC_W-1:0] r_lr;
  logic            w_lr_en;

  assign w_lr_en = (r_state == StExecute) && ex_done && jump && link && !halt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lr <= '0;
    end else if (w_lr_en) begin
      r_lr <= r_pc + 8'd1;
    end
  end

  assign lr = r_lr;
`else
  logic w_unused_link;
  assign w_unused_link = link;
  assign lr            = '0;
`endif

  assign imem.imem_req  = (r_state == StFetch);
  assign imem.imem_addr = r_pc;
  assign ir             = r_ir;
  assign ir_valid       = (r_state == StDecode);
  assign imm5           = r_ir[IMM_LSB +: IMM_W];
  assign pc             = r_pc;
  assign halted         = (r_state == StHalt);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed table, corner sequences, random instructions.
module tb_pc_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ir;
  logic       ir_valid;
  logic [4:0] imm5;
  logic [7:0] sext_imm;
  logic       ex_done;
  logic       branch_taken;
  logic       jump;
  logic [7:0] jump_target;
  logic       halt;
  logic       link;
  logic [7:0] lr;
  logic [7:0] pc;
  logic       halted;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_pc;
  logic [7:0] m_lr;

  pc_fetch_unit_if u_if ();

  pc_fetch_unit #(
    .RESET_PC (8'h20)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem         (u_if.master),
    .ir           (ir),
    .ir_valid     (ir_valid),
    .imm5         (imm5),
    .sext_imm     (sext_imm),
    .ex_done      (ex_done),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jump_target  (jump_target),
    .halt         (halt),
    .link         (link),
    .lr           (lr),
    .pc           (pc),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic junk_ctl();
    halt         = 1'($urandom);
    jump         = 1'($urandom);
    branch_taken = 1'($urandom);
    link         = 1'($urandom);
    jump_target  = 8'($urandom);
    sext_imm     = 8'($urandom);
    ex_done      = 1'b0;
  endtask

  // Reference next state from the architectural rules, in plain arithmetic.
  task automatic model_exec(input logic h, input logic j, input logic b, input logic [7:0] tgt,
                            input logic [7:0] sx, input logic lk);
    int unsigned base;
    if (h) return;
    base = (int'(m_pc) + 1) % 256;
`ifdef PC_LINK_EN
    if (j && lk) m_lr = 8'(base);
`else
    if (lk) m_lr = 8'h00;
`endif
    if (j)      m_pc = tgt;
    else if (b) m_pc = 8'((base + int'(sx)) % 256);
    else        m_pc = 8'(base);
  endtask

  // Runs one instruction starting with the DUT in FETCH, sampled at a negedge.
  task automatic do_instr(input int unsigned ack_dly, input logic [7:0] data,
                          input int unsigned ex_dly, input logic h, input logic j,
                          input logic b, input logic [7:0] tgt, input logic [7:0] sx,
                          input logic lk);
    chk("fetch_req", {31'd0, u_if.imem_req}, 32'd1);
    chk("fetch_addr", {24'd0, u_if.imem_addr}, {24'd0, m_pc});
    for (int i = 0; i < int'(ack_dly); i++) begin
      u_if.imem_ack  = 1'b0;
      u_if.imem_data = 8'($urandom);
      junk_ctl();
      step();
      chk("wait_req", {31'd0, u_if.imem_req}, 32'd1);
      chk("wait_addr", {24'd0, u_if.imem_addr}, {24'd0, m_pc});
    end
    u_if.imem_ack  = 1'b1;
    u_if.imem_data = data;
    step();
    u_if.imem_ack  = 1'b0;
    u_if.imem_data = 8'($urandom);
    junk_ctl();
    chk("decode_irv", {31'd0, ir_valid}, 32'd1);
    chk("decode_ir", {24'd0, ir}, {24'd0, data});
    chk("decode_imm5", {27'd0, imm5}, {27'd0, data[4:0]});
    chk("decode_req", {31'd0, u_if.imem_req}, 32'd0);
    step();
    chk("exec_irv", {31'd0, ir_valid}, 32'd0);
    for (int i = 0; i < int'(ex_dly); i++) begin
      junk_ctl();
      step();
      chk("exwait_pc", {24'd0, pc}, {24'd0, m_pc});
      chk("exwait_halted", {31'd0, halted}, 32'd0);
    end
    halt         = h;
    jump         = j;
    branch_taken = b;
    jump_target  = tgt;
    sext_imm     = sx;
    link         = lk;
    ex_done      = 1'b1;
    step();
    ex_done = 1'b0;
    model_exec(h, j, b, tgt, sx, lk);
    chk("exec_pc", {24'd0, pc}, {24'd0, m_pc});
    chk("exec_lr", {24'd0, lr}, {24'd0, m_lr});
    chk("exec_ir_hold", {24'd0, ir}, {24'd0, data});
    chk("exec_halted", {31'd0, halted}, {31'd0, h});
    chk("exec_next_req", {31'd0, u_if.imem_req}, {31'd0, !h});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    u_if.imem_ack = 1'b0;
    junk_ctl();
    step();
    step();
    m_pc = 8'h20;
    m_lr = 8'h00;
    chk("rst_pc", {24'd0, pc}, 32'h20);
    chk("rst_ir", {24'd0, ir}, 32'h0);
    chk("rst_lr", {24'd0, lr}, 32'h0);
    chk("rst_req", {31'd0, u_if.imem_req}, 32'd0);
    chk("rst_irv", {31'd0, ir_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_imm5", {27'd0, imm5}, 32'd0);
    rst_n = 1'b1;
    chk("idle_req", {31'd0, u_if.imem_req}, 32'd0);
    step();
    chk("first_req", {31'd0, u_if.imem_req}, 32'd1);
    chk("first_addr", {24'd0, u_if.imem_addr}, 32'h20);
  endtask

  typedef struct {
    logic [7:0] start;
    logic [7:0] sext;
    logic [7:0] target;
    logic       jump;
    logic       br;
    logic       link;
    logic [7:0] exp_pc;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [7:0] exp_lr;
    logic [7:0] pc_before;
    logic [7:0] d;

    tbl[0] = '{start: 8'h10, sext: 8'hF0, target: 8'h99, jump: 1'b0, br: 1'b1, link: 1'b0,
               exp_pc: 8'h01};
    tbl[1] = '{start: 8'hFF, sext: 8'h05, target: 8'h99, jump: 1'b0, br: 1'b0, link: 1'b0,
               exp_pc: 8'h00};
    tbl[2] = '{start: 8'h05, sext: 8'h03, target: 8'h40, jump: 1'b1, br: 1'b1, link: 1'b0,
               exp_pc: 8'h40};
    tbl[3] = '{start: 8'h7F, sext: 8'h05, target: 8'h11, jump: 1'b0, br: 1'b1, link: 1'b0,
               exp_pc: 8'h85};
    tbl[4] = '{start: 8'hF0, sext: 8'h0F, target: 8'h11, jump: 1'b0, br: 1'b1, link: 1'b0,
               exp_pc: 8'h00};
    tbl[5] = '{start: 8'h33, sext: 8'h00, target: 8'h80, jump: 1'b1, br: 1'b0, link: 1'b1,
               exp_pc: 8'h80};

    rst_n          = 1'b0;
    u_if.imem_ack  = 1'b0;
    u_if.imem_data = 8'h00;
    junk_ctl();
    @(negedge clk);
    do_reset();

    // Delayed ack keeps the address stable and captures the byte once.
    do_instr(3, 8'hB7, 0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("b7_pc", {24'd0, pc}, 32'h21);

    for (int k = 0; k < 6; k++) begin
      do_instr($urandom_range(0, 2), 8'($urandom), $urandom_range(0, 2),
               1'b0, 1'b1, 1'b0, tbl[k].start, 8'h00, 1'b0);
      do_instr($urandom_range(0, 2), 8'($urandom), $urandom_range(0, 2),
               1'b0, tbl[k].jump, tbl[k].br, tbl[k].target, tbl[k].sext, tbl[k].link);
      chk($sformatf("tbl%0d_pc", k), {24'd0, pc}, {24'd0, tbl[k].exp_pc});
    end
`ifdef PC_LINK_EN
    exp_lr = 8'h34;
`else
    exp_lr = 8'h00;
`endif
    chk("link_lr", {24'd0, lr}, {24'd0, exp_lr});

    // Halt beats jump and branch; no fetch afterwards.
    pc_before = pc;
    do_instr(0, 8'h12, 1, 1'b1, 1'b1, 1'b1, 8'h40, 8'h07, 1'b1);
    chk("halt_pc", {24'd0, pc}, {24'd0, pc_before});
    chk("halt_lr_kept", {24'd0, lr}, {24'd0, exp_lr});
    for (int i = 0; i < 5; i++) begin
      junk_ctl();
      ex_done = 1'($urandom);
      u_if.imem_ack = 1'($urandom);
      step();
      chk("halt_no_req", {31'd0, u_if.imem_req}, 32'd0);
      chk("halt_stays", {31'd0, halted}, 32'd1);
    end
    ex_done = 1'b0;
    do_reset();

    // Reset during an outstanding fetch; the late ack must be dropped.
    do_instr(0, 8'h6C, 0, 1'b0, 1'b1, 1'b0, 8'h55, 8'h00, 1'b0);
    u_if.imem_ack = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n          = 1'b1;
    u_if.imem_ack  = 1'b1;
    u_if.imem_data = 8'hA5;
    m_pc = 8'h20;
    m_lr = 8'h00;
    chk("midrst_req", {31'd0, u_if.imem_req}, 32'd0);
    chk("midrst_ir", {24'd0, ir}, 32'h0);
    chk("midrst_pc", {24'd0, pc}, 32'h20);
    chk("midrst_lr", {24'd0, lr}, 32'h0);
    step();
    u_if.imem_ack = 1'b0;
    chk("late_ack_ir", {24'd0, ir}, 32'h0);
    chk("late_ack_irv", {31'd0, ir_valid}, 32'd0);
    chk("late_ack_req", {31'd0, u_if.imem_req}, 32'd1);

    for (int n = 0; n < 40; n++) begin
      d = 8'($urandom);
      do_instr($urandom_range(0, 3), d, $urandom_range(0, 3), 1'b0,
               ($urandom_range(0, 3) == 0), 1'($urandom), 8'($urandom),
               {{3{d[4]}}, d[4:0]}, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
